// File: rtl/ex_md_unit.sv
// ---------------------------------------------------------------------------
// ex_md_unit
//   EX-stage multiply/divide unit. It owns the architectural HI/LO registers
//   and executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
//   A multiply takes 2 stall cycles. A divide is a radix-2 restoring divider
//   that takes 33 stall cycles: one entry cycle plus DIV_ITER iterations.
//
// Ports
//   clk               : clock
//   rst               : synchronous active-high reset
//   EX_in_MDop[7:0]   : one-hot op, bits in order MULT, MULTU, DIV, DIVU,
//                       MFHI, MFLO, MTHI, MTLO (all zero = no op)
//   EX_in_RF_rs_data  : multiplicand / dividend / MTHI-MTLO source
//   EX_in_RF_rt_data  : multiplier / divisor
//   MEM_stall         : downstream hold; the EX instruction does not advance
//   md_stall          : high while a mult/div occupies EX
//   md_result[31:0]   : HI for MFHI, LO for MFLO, 0 otherwise (combinational)
//   hi_out / lo_out   : current HI / LO
// ---------------------------------------------------------------------------
module ex_md_unit #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  EX_in_MDop,
  input  logic [31:0] EX_in_RF_rs_data,
  input  logic [31:0] EX_in_RF_rt_data,
  input  logic        MEM_stall,
  output logic        md_stall,
  output logic [31:0] md_result,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CW = $clog2(DIV_ITER);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t        r_state;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [63:0]   r_prod;
  logic [31:0]   r_rem;
  logic [31:0]   r_quo;
  logic [31:0]   r_dvsr;
  logic [CW-1:0] r_cnt;
  logic          r_qsign;
  logic          r_rsign;

  // Isolate the lowest set bit of the opcode so that, with more than one
  // bit set, the lowest-numbered operation wins.
  logic [7:0] w_sel;
  assign w_sel = EX_in_MDop & (~EX_in_MDop + 8'd1);

  logic w_start_mul;
  logic w_start_div;
  assign w_start_mul = w_sel[0] | w_sel[1];
  assign w_start_div = w_sel[2] | w_sel[3];

  // Products: both operands are widened to 64 bits first, so the low 64
  // bits of the product are exact for both signed and unsigned forms.
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_prod;
  assign w_prod_s = $signed({{32{EX_in_RF_rs_data[31]}}, EX_in_RF_rs_data})
                  * $signed({{32{EX_in_RF_rt_data[31]}}, EX_in_RF_rt_data});
  assign w_prod_u = {32'd0, EX_in_RF_rs_data} * {32'd0, EX_in_RF_rt_data};
  assign w_prod   = w_sel[0] ? w_prod_s : w_prod_u;

  // Divide operand magnitudes. Raw values are used for DIVU.
  // Negating 0x80000000 gives 0x80000000, which is the correct unsigned
  // magnitude, so the signed corner case needs no special handling.
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_abs;
  logic [31:0] w_rt_abs;
  assign w_rs_neg = w_sel[2] & EX_in_RF_rs_data[31];
  assign w_rt_neg = w_sel[2] & EX_in_RF_rt_data[31];
  assign w_rs_abs = w_rs_neg ? -EX_in_RF_rs_data : EX_in_RF_rs_data;
  assign w_rt_abs = w_rt_neg ? -EX_in_RF_rt_data : EX_in_RF_rt_data;

  // One restoring step. The divider keeps r_rem < r_dvsr, so the 33-bit
  // trial difference's MSB is a reliable "went negative" flag.
  logic [32:0] w_rem_sh;
  logic [32:0] w_trial;
  logic [31:0] w_rem_step;
  logic [31:0] w_quo_step;
  assign w_rem_sh   = {r_rem, r_quo[31]};
  assign w_trial    = w_rem_sh - {1'b0, r_dvsr};
  assign w_rem_step = w_trial[32] ? w_rem_sh[31:0] : w_trial[31:0];
  assign w_quo_step = {r_quo[30:0], ~w_trial[32]};

  // Final sign correction. A zero divisor leaves the quotient all-ones
  // and the remainder equal to |rs|. LO is forced to all-ones so the signed
  // correction cannot alter it, while the remainder correction restores
  // the original rs into HI.
  logic        w_div_last;
  logic [31:0] w_hi_fin;
  logic [31:0] w_lo_fin;
  assign w_div_last = (r_cnt == CW'(DIV_ITER - 1));
  assign w_hi_fin   = r_rsign ? -w_rem_step : w_rem_step;
  assign w_lo_fin   = (r_dvsr == 32'd0) ? 32'hFFFF_FFFF
                    : (r_qsign ? -w_quo_step : w_quo_step);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_prod  <= 64'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvsr  <= 32'd0;
      r_cnt   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_mul) begin
            r_prod  <= w_prod;
            r_state <= S_MUL;
          end else if (w_start_div) begin
            r_rem   <= 32'd0;
            r_quo   <= w_rs_abs;
            r_dvsr  <= w_rt_abs;
            r_qsign <= w_rs_neg ^ w_rt_neg;
            r_rsign <= w_rs_neg;
            r_cnt   <= '0;
            r_state <= S_DIV;
          end else if (!MEM_stall) begin
            if (w_sel[6]) r_hi <= EX_in_RF_rs_data;
            if (w_sel[7]) r_lo <= EX_in_RF_rs_data;
          end
        end
        S_MUL: begin
          r_hi    <= r_prod[63:32];
          r_lo    <= r_prod[31:0];
          r_state <= S_DONE;
        end
        S_DIV: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt + 1'b1;
          if (w_div_last) begin
            r_hi    <= w_hi_fin;
            r_lo    <= w_lo_fin;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // The finished instruction stays in EX until MEM releases it,
          // and it must not restart.
          if (!MEM_stall) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign md_stall  = ((r_state == S_IDLE) && (w_start_mul || w_start_div))
                   || (r_state == S_MUL) || (r_state == S_DIV);
  assign md_result = w_sel[4] ? r_hi : (w_sel[5] ? r_lo : 32'd0);
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;

endmodule

// File: tb/tb_ex_md_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_md_unit
//   Table-driven bench for ex_md_unit with a scoreboard queue, followed by
//   hand-written sequences covering a MEM_stall hold in DONE and a reset in
//   the middle of a divide.
// ---------------------------------------------------------------------------
module tb_ex_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mdop;
  logic [31:0] rs_d;
  logic [31:0] rt_d;
  logic        mem_stall;
  logic        md_stall;
  logic [31:0] md_result;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  ex_md_unit #(.DIV_ITER(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .EX_in_MDop       (mdop),
    .EX_in_RF_rs_data (rs_d),
    .EX_in_RF_rt_data (rt_d),
    .MEM_stall        (mem_stall),
    .md_stall         (md_stall),
    .md_result        (md_result),
    .hi_out           (hi_out),
    .lo_out           (lo_out)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] OP_MULT  = 8'h01;
  localparam logic [7:0] OP_MULTU = 8'h02;
  localparam logic [7:0] OP_DIV   = 8'h04;
  localparam logic [7:0] OP_DIVU  = 8'h08;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h20;
  localparam logic [7:0] OP_MTHI  = 8'h40;
  localparam logic [7:0] OP_MTLO  = 8'h80;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    int          stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one instruction, count md_stall cycles, let it leave EX, then
  // compare against the scoreboard entry pushed at drive time.
  task automatic run_op(input logic [7:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int st, input logic [31:0] hi, input logic [31:0] lo,
                        input logic [31:0] res);
    exp_t        e;
    exp_t        g;
    int          cyc;
    logic [31:0] res_seen;
    @(negedge clk);
    mdop = op;
    rs_d = rs;
    rt_d = rt;
    e.stall = st;
    e.hi    = hi;
    e.lo    = lo;
    e.res   = res;
    sb.push_back(e);
    #1;
    res_seen = md_result;
    cyc = 0;
    while (md_stall === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    mdop = 8'h00;
    #1;
    g = sb.pop_front();
    chk("stall_cycles", 32'(cyc), 32'(g.stall));
    chk("md_result", res_seen, g.res);
    chk("hi", hi_out, g.hi);
    chk("lo", lo_out, g.lo);
    $display("op=%02h rs=%08h rt=%08h stall=%0d res=%08h hi=%08h lo=%08h",
             op, rs, rt, cyc, res_seen, hi_out, lo_out);
  endtask

  vec_t vecs[19];

  initial begin
    int cyc;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h2,        2,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h2,        2,  32'h00000001, 32'hFFFFFFFE, 32'h0};
    vecs[2]  = '{OP_MFHI,  32'h0,        32'h0,        0,  32'h00000001, 32'hFFFFFFFE, 32'h1};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        33, 32'd2,        32'd14,       32'h0};
    vecs[4]  = '{OP_MFLO,  32'h0,        32'h0,        0,  32'd2,        32'd14,       32'd14};
    vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0};
    vecs[6]  = '{OP_DIV,   32'h7,        32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD, 32'h0};
    vecs[7]  = '{OP_DIV,   32'h12345678, 32'h0,        33, 32'h12345678, 32'hFFFFFFFF, 32'h0};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000, 32'h0};
    vecs[9]  = '{OP_DIV,   32'hF0000000, 32'h0,        33, 32'hF0000000, 32'hFFFFFFFF, 32'h0};
    vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       33, 32'h0000000F, 32'h0FFFFFFF, 32'h0};
    vecs[11] = '{OP_MTHI,  32'hDEADBEEF, 32'h0,        0,  32'hDEADBEEF, 32'h0FFFFFFF, 32'h0};
    vecs[12] = '{OP_MTLO,  32'hCAFEF00D, 32'h0,        0,  32'hDEADBEEF, 32'hCAFEF00D, 32'h0};
    vecs[13] = '{8'h30,    32'h0,        32'h0,        0,  32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[14] = '{8'h06,    32'h00010000, 32'h00010000, 2,  32'h00000001, 32'h00000000, 32'h0};
    vecs[15] = '{8'hC0,    32'h00000055, 32'h0,        0,  32'h00000055, 32'h00000000, 32'h0};
    vecs[16] = '{8'h28,    32'd100,      32'd10,       33, 32'h00000000, 32'd10,       32'h0};
    vecs[17] = '{OP_MULT,  32'h80000000, 32'h80000000, 2,  32'h40000000, 32'h00000000, 32'h0};
    vecs[18] = '{8'h00,    32'h12345678, 32'h9,        0,  32'h40000000, 32'h00000000, 32'h0};

    rst       = 1'b1;
    mdop      = 8'h00;
    rs_d      = 32'h0;
    rt_d      = 32'h0;
    mem_stall = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_md_stall", {31'd0, md_stall}, 32'd0);
    chk("reset_md_result", md_result, 32'd0);
    chk("reset_hi", hi_out, 32'd0);
    chk("reset_lo", lo_out, 32'd0);

    for (int i = 0; i < 19; i++)
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].stall,
             vecs[i].hi, vecs[i].lo, vecs[i].res);

    // MULT finishing while MEM holds the pipeline for several cycles.
    @(negedge clk);
    mdop = OP_MULT;
    rs_d = 32'd3;
    rt_d = 32'd5;
    #1;
    cyc = 0;
    while (md_stall === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("memhold_stall_cycles", 32'(cyc), 32'd2);
    mem_stall = 1'b1;
    chk("memhold_done_lo", lo_out, 32'd15);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("memhold_md_stall", {31'd0, md_stall}, 32'd0);
      chk("memhold_hi", hi_out, 32'd0);
      chk("memhold_lo", lo_out, 32'd15);
    end
    mem_stall = 1'b0;
    @(negedge clk);
    mdop = 8'h00;
    #1;
    chk("memhold_release_md_stall", {31'd0, md_stall}, 32'd0);
    $display("memhold seq: hi=%08h lo=%08h", hi_out, lo_out);
    run_op(OP_MFLO, 32'h0, 32'h0, 0, 32'h0, 32'd15, 32'd15);
    run_op(OP_MULT, 32'd2, 32'd3, 2, 32'h0, 32'd6, 32'h0);

    // MTHI must not write while MEM_stall is high.
    @(negedge clk);
    mem_stall = 1'b1;
    mdop      = OP_MTHI;
    rs_d      = 32'h77;
    @(negedge clk);
    mdop      = 8'h00;
    mem_stall = 1'b0;
    #1;
    chk("mthi_under_mem_stall", hi_out, 32'h0);
    $display("mthi under MEM_stall: hi=%08h", hi_out);

    // Reset in the middle of a divide.
    run_op(OP_MTHI, 32'hAAAA5555, 32'h0, 0, 32'hAAAA5555, 32'd6, 32'h0);
    @(negedge clk);
    mdop = OP_DIV;
    rs_d = 32'd100;
    rt_d = 32'd3;
    repeat (11) @(negedge clk);
    #1;
    chk("middiv_md_stall", {31'd0, md_stall}, 32'd1);
    rst  = 1'b1;
    mdop = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_md_stall", {31'd0, md_stall}, 32'd0);
    chk("midrst_hi", hi_out, 32'd0);
    chk("midrst_lo", lo_out, 32'd0);
    $display("reset mid-divide: hi=%08h lo=%08h stall=%0d", hi_out, lo_out, md_stall);
    run_op(OP_MTLO, 32'h5, 32'h0, 0, 32'h0, 32'h5, 32'h0);
    run_op(OP_MFLO, 32'h0, 32'h0, 0, 32'h0, 32'h5, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_md_unit.md
Name: ex_md_unit

Overview:
- Multiply/divide unit in the EX stage, driven by the ID/EX pipeline register outputs: MDop, rs data and rt data.
- Owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Asserts md_stall while an operation is in flight so the ID/EX register holds its current instruction.
- Multiply takes 2 cycles; divide is radix-2 restoring over 32 iterations.

Parameters:
- DIV_ITER, 32, number of divide iterations (fixed at 32 for 32-bit operands).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high, sampled on posedge clk.
- EX_in_MDop  input  8  one-hot opcode: [0] MULT, [1] MULTU, [2] DIV, [3] DIVU, [4] MFHI, [5] MFLO, [6] MTHI, [7] MTLO. All-zero means no op, including bubbles.
- EX_in_RF_rs_data  input  32  multiplicand / dividend / MTHI-MTLO source.
- EX_in_RF_rt_data  input  32  multiplier / divisor.
- MEM_stall  input  1  downstream hold; while high, the EX instruction does not advance.
- md_stall  output  1  high while a mult/div occupies EX; top level ORs it into EX_stall.
- md_result  output  32  HI for MFHI, LO for MFLO, 0 otherwise. Combinational.
- hi_out  output  32  current HI.
- lo_out  output  32  current LO.

Behaviour:
- Reset:
  - state=IDLE, HI=0, LO=0, iteration counter=0, operand/partial registers=0.
  - md_stall=0; md_result=0 (MDop is 0 after reset).
  - Reset mid-operation aborts the operation; HI/LO are not updated with a partial result.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - MDop[0] or [1]: md_stall=1 combinationally. On the edge, register the 64-bit product (signed for [0], unsigned for [1]); go to MUL.
  - MDop[2] or [3]: md_stall=1. On the edge, latch |rs| and |rt| (raw values for DIVU), the quotient sign (rs[31]^rt[31]) and the remainder sign (rs[31]), both signed only; clear counter; go to DIV.
  - MTHI / MTLO: HI/LO <= rs on the edge when MEM_stall=0. No stall.
  - MFHI / MFLO: no state change.
- MUL:
  - md_stall=1. On the edge, HI <= product[63:32], LO <= product[31:0]; go to DONE.
  - Total stall = 2 cycles.
- DIV:
  - md_stall=1. Each cycle performs one restoring step: shift the {rem, quo} pair left 1, trial-subtract the divisor, set quotient bit if non-negative.
  - Counter increments 0..31. On the edge with counter==31, write HI=remainder and LO=quotient, sign-corrected by two's-complement negation where the latched signs require it; go to DONE.
  - Total stall = 33 cycles (entry cycle + 32 iterations).
- DONE:
  - md_stall=0, so the same instruction is allowed to leave EX.
  - If MEM_stall=0, go to IDLE on the edge. If MEM_stall=1, stay in DONE; no restart, HI/LO unchanged.
- Divide by zero (rt=0, signed or unsigned): still 33 cycles; result LO=32'hFFFFFFFF, HI=rs (original, uncorrected). No exception.
- Signed corner 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps).
- MDop with more than one bit set: the lowest set bit wins.
- MDop changes while in MUL or DIV: ignored. Operands were latched at entry.
- MFHI/MFLO in the cycle after DONE, or after an MT* write, read the updated register (register read, no bypass needed).
- No operation other than mult/div ever asserts md_stall.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=2 -> md_stall high exactly 2 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
- DIVU rs=100, rt=7 -> md_stall high 33 cycles; DONE cycle shows LO=14, HI=2; a following MFLO gives md_result=14.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV rs=7, rt=-2 -> LO=0xFFFFFFFD, HI=1.
- DIV rs=0x12345678, rt=0 -> 33 stall cycles; LO=0xFFFFFFFF, HI=0x12345678.
- MULT completes with MEM_stall=1 for 3 cycles in DONE -> md_stall stays 0, state stays DONE, HI/LO written once and unchanged; MEM_stall falls -> IDLE next cycle, no second multiply.
- rst asserted at DIV iteration 10 after MTHI 0xAAAA5555 -> next cycle state=IDLE, md_stall=0, HI=LO=0; a subsequent MTLO 0x5 followed by MFLO -> md_result=0x5.
